// File: rtl/bomb_pkg.sv
// rtl/bomb_pkg.sv - shared types, encodings and blast geometry for the bomb scheduler
package bomb_pkg;

   typedef logic [2:0] coord_t;

   typedef enum logic [1:0] {
      SLOT_IDLE    = 2'd0,
      SLOT_ARMED   = 2'd1,
      SLOT_EXPLODE = 2'd2
   } slot_state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_A    = 2'b01;
   localparam logic [1:0] WIN_B    = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   // Unsigned distances on the 8x8 grid, so the arms clip at the edges instead of wrapping.
   function automatic logic in_cross(input coord_t bx, input coord_t by,
                                     input coord_t px, input coord_t py,
                                     input coord_t rad);
      coord_t dx;
      coord_t dy;
      dx = (bx > px) ? bx - px : px - bx;
      dy = (by > py) ? by - py : py - by;
      return ((by == py) && (dx <= rad)) || ((bx == px) && (dy <= rad));
   endfunction

   function automatic logic [1:0] sat_sub(input logic [1:0] h, input logic [1:0] d);
      return (h > d) ? h - d : 2'd0;
   endfunction

endpackage

// File: rtl/bomb_slot.sv
// rtl/bomb_slot.sv - one bomb slot: idle/armed/exploding FSM, cycle counter, latched cell
module bomb_slot
   import bomb_pkg::*;
#(
   parameter int BOMB_PERIOD  = 100000,
   parameter int FUSE_PERIODS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        chain_trigger,
   input  logic        force_idle,
   input  coord_t      load_x,
   input  coord_t      load_y,
   output slot_state_t state,
   output coord_t      x,
   output coord_t      y,
   output logic        fire,
   output logic        first_blast
);

   localparam int FUSE_CYCLES = FUSE_PERIODS * BOMB_PERIOD;
   localparam int CW = $clog2(FUSE_CYCLES + 1);
   localparam logic [CW-1:0] FUSE_LAST  = CW'(FUSE_CYCLES - 1);
   localparam logic [CW-1:0] BLAST_LAST = CW'(BOMB_PERIOD - 1);

   logic [CW-1:0] cnt;

   // fire marks the edge that enters EXPLODE; the top applies damage on that same edge.
   assign fire        = (state == SLOT_ARMED) && !force_idle && ((cnt == FUSE_LAST) || chain_trigger);
   assign first_blast = (state == SLOT_EXPLODE) && (cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= SLOT_IDLE;
         cnt   <= '0;
         x     <= '0;
         y     <= '0;
      end else if (force_idle) begin
         state <= SLOT_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            SLOT_IDLE: begin
               if (load) begin
                  state <= SLOT_ARMED;
                  cnt   <= '0;
                  x     <= load_x;
                  y     <= load_y;
               end
            end
            SLOT_ARMED: begin
               if (fire) begin
                  state <= SLOT_EXPLODE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            SLOT_EXPLODE: begin
               if (cnt == BLAST_LAST) begin
                  state <= SLOT_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= SLOT_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/bomb_scheduler.sv
// rtl/bomb_scheduler.sv - drop arbitration, chain triggering, blast damage and game-over for two players
module bomb_scheduler
   import bomb_pkg::*;
#(
   parameter int BOMB_PERIOD  = 100000,
   parameter int FUSE_PERIODS = 2,
   parameter int RADIUS       = 1,
   parameter int HEALTH_INIT  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       drop_a,
   input  logic       drop_b,
   input  logic [2:0] pos_ax,
   input  logic [2:0] pos_ay,
   input  logic [2:0] pos_bx,
   input  logic [2:0] pos_by,
   output logic [1:0] bomb_state_a,
   output logic [1:0] bomb_state_b,
   output logic [2:0] bomb_ax,
   output logic [2:0] bomb_ay,
   output logic [2:0] bomb_bx,
   output logic [2:0] bomb_by,
   output logic [1:0] health_a,
   output logic [1:0] health_b,
   output logic       game_over,
   output logic [1:0] winner
);

   localparam coord_t     RAD = coord_t'(RADIUS);
   localparam logic [1:0] H0  = 2'(HEALTH_INIT);

   slot_state_t state_a, state_b;
   logic        fire_a, fire_b, first_a, first_b;
   logic        ok_a, ok_b, collide, load_a, load_b, chain_a, chain_b;
   logic        prio_b;
   logic [1:0]  dmg_a, dmg_b, next_a, next_b;

   assign ok_a = drop_a && (state_a == SLOT_IDLE) && !game_over &&
                 !((state_b != SLOT_IDLE) && (pos_ax == bomb_bx) && (pos_ay == bomb_by));
   assign ok_b = drop_b && (state_b == SLOT_IDLE) && !game_over &&
                 !((state_a != SLOT_IDLE) && (pos_bx == bomb_ax) && (pos_by == bomb_ay));

   // prio_b low means A owns the tie-break for a same-cell simultaneous drop.
   assign collide = ok_a && ok_b && (pos_ax == pos_bx) && (pos_ay == pos_by);
   assign load_a  = ok_a && !(collide && prio_b);
   assign load_b  = ok_b && !(collide && !prio_b);

   assign chain_a = (state_a == SLOT_ARMED) && first_b && in_cross(bomb_bx, bomb_by, bomb_ax, bomb_ay, RAD);
   assign chain_b = (state_b == SLOT_ARMED) && first_a && in_cross(bomb_ax, bomb_ay, bomb_bx, bomb_by, RAD);

   assign dmg_a = {1'b0, fire_a && in_cross(bomb_ax, bomb_ay, pos_ax, pos_ay, RAD)} +
                  {1'b0, fire_b && in_cross(bomb_bx, bomb_by, pos_ax, pos_ay, RAD)};
   assign dmg_b = {1'b0, fire_a && in_cross(bomb_ax, bomb_ay, pos_bx, pos_by, RAD)} +
                  {1'b0, fire_b && in_cross(bomb_bx, bomb_by, pos_bx, pos_by, RAD)};
   assign next_a = sat_sub(health_a, dmg_a);
   assign next_b = sat_sub(health_b, dmg_b);

   bomb_slot #(.BOMB_PERIOD(BOMB_PERIOD), .FUSE_PERIODS(FUSE_PERIODS)) u_slot_a (
      .clk(clk), .rst(rst), .load(load_a), .chain_trigger(chain_a), .force_idle(game_over),
      .load_x(pos_ax), .load_y(pos_ay), .state(state_a), .x(bomb_ax), .y(bomb_ay),
      .fire(fire_a), .first_blast(first_a)
   );

   bomb_slot #(.BOMB_PERIOD(BOMB_PERIOD), .FUSE_PERIODS(FUSE_PERIODS)) u_slot_b (
      .clk(clk), .rst(rst), .load(load_b), .chain_trigger(chain_b), .force_idle(game_over),
      .load_x(pos_bx), .load_y(pos_by), .state(state_b), .x(bomb_bx), .y(bomb_by),
      .fire(fire_b), .first_blast(first_b)
   );

   assign bomb_state_a = state_a;
   assign bomb_state_b = state_b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         health_a  <= H0;
         health_b  <= H0;
         game_over <= 1'b0;
         winner    <= WIN_NONE;
         prio_b    <= 1'b0;
      end else begin
         if (collide)
            prio_b <= !prio_b;
         if (!game_over) begin
            health_a <= next_a;
            health_b <= next_b;
            if ((next_a == 2'd0) || (next_b == 2'd0)) begin
               game_over <= 1'b1;
               if ((next_a == 2'd0) && (next_b == 2'd0))
                  winner <= WIN_DRAW;
               else if (next_a == 2'd0)
                  winner <= WIN_B;
               else
                  winner <= WIN_A;
            end
         end
      end
   end

endmodule

// File: tb/tb_bomb_scheduler.sv
// tb/tb_bomb_scheduler.sv - scoreboard bench: scenarios queue expected outputs, a negedge monitor compares
module tb_bomb_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       drop_a = 1'b0, drop_b = 1'b0;
   logic [2:0] pos_ax = '0, pos_ay = '0, pos_bx = '0, pos_by = '0;
   logic [1:0] bomb_state_a, bomb_state_b, health_a, health_b, winner;
   logic [2:0] bomb_ax, bomb_ay, bomb_bx, bomb_by;
   logic       game_over;

   typedef struct packed {
      logic [1:0] sa, sb;
      logic [2:0] ax, ay, bx, by;
      logic [1:0] ha, hb;
      logic       go;
      logic [1:0] win;
   } obs_t;

   typedef struct {
      int    cyc;
      string name;
      obs_t  v;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;
   obs_t r0;

   bomb_scheduler #(.BOMB_PERIOD(10), .FUSE_PERIODS(2), .RADIUS(1), .HEALTH_INIT(3)) dut (
      .clk(clk), .rst(rst), .drop_a(drop_a), .drop_b(drop_b),
      .pos_ax(pos_ax), .pos_ay(pos_ay), .pos_bx(pos_bx), .pos_by(pos_by),
      .bomb_state_a(bomb_state_a), .bomb_state_b(bomb_state_b),
      .bomb_ax(bomb_ax), .bomb_ay(bomb_ay), .bomb_bx(bomb_bx), .bomb_by(bomb_by),
      .health_a(health_a), .health_b(health_b), .game_over(game_over), .winner(winner)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic obs_t mk(input int sa, input int sb, input int ax, input int ay,
                               input int bx, input int by, input int ha, input int hb,
                               input int go, input int win);
      obs_t v;
      v.sa = sa[1:0]; v.sb = sb[1:0];
      v.ax = ax[2:0]; v.ay = ay[2:0]; v.bx = bx[2:0]; v.by = by[2:0];
      v.ha = ha[1:0]; v.hb = hb[1:0];
      v.go = go[0];   v.win = win[1:0];
      return v;
   endfunction

   function automatic string fmt(input obs_t v);
      return $sformatf("sa=%0d sb=%0d a=(%0d,%0d) b=(%0d,%0d) ha=%0d hb=%0d go=%0d win=%b",
                       v.sa, v.sb, v.ax, v.ay, v.bx, v.by, v.ha, v.hb, v.go, v.win);
   endfunction

   task automatic push_exp(input int dc, input string nm, input obs_t v);
      exp_t e;
      e.cyc = cyc + dc; e.name = nm; e.v = v;
      exp_q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_pos(input int ax, input int ay, input int bx, input int by);
      pos_ax = ax[2:0]; pos_ay = ay[2:0]; pos_bx = bx[2:0]; pos_by = by[2:0];
   endtask

   task automatic do_reset();
      tick(1);
      drop_a = 1'b0; drop_b = 1'b0;
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   always @(negedge clk) begin
      obs_t act;
      exp_t e;
      act = {bomb_state_a, bomb_state_b, bomb_ax, bomb_ay, bomb_bx, bomb_by,
             health_a, health_b, game_over, winner};
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (e.cyc < cyc || act !== e.v) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %s, expected %s", e.name, cyc, fmt(act), fmt(e.v));
         end
      end
   end

   initial begin
      int s;
      r0 = mk(0, 0, 0, 0, 0, 0, 3, 3, 0, 0);

      // reset state
      do_reset();
      push_exp(0, "reset_state", r0);
      n_cmp++;
      if (health_a !== 2'd3) begin
         n_fail++;
         $display("FAIL direct_reset_health_a: got %0d", health_a);
      end
      n_cmp++;
      if (health_b !== 2'd3) begin
         n_fail++;
         $display("FAIL direct_reset_health_b: got %0d", health_b);
      end
      n_cmp++;
      if (bomb_state_a !== 2'd0 || bomb_state_b !== 2'd0) begin
         n_fail++;
         $display("FAIL direct_reset_slots: got %0d %0d", bomb_state_a, bomb_state_b);
      end
      n_cmp++;
      if (game_over !== 1'b0 || winner !== 2'b00) begin
         n_fail++;
         $display("FAIL direct_reset_game: go=%0d win=%b", game_over, winner);
      end

      // s1: single bomb at (0,0), fuse/blast timing, late drop rejected, first idle drop accepted
      set_pos(0, 0, 7, 7);
      s = cyc;
      push_exp(1,  "s1_armed",        mk(1, 0, 0, 0, 0, 0, 3, 3, 0, 0));
      push_exp(20, "s1_fuse_hold",    mk(1, 0, 0, 0, 0, 0, 3, 3, 0, 0));
      push_exp(21, "s1_explode",      mk(2, 0, 0, 0, 0, 0, 2, 3, 0, 0));
      push_exp(30, "s1_blast_hold",   mk(2, 0, 0, 0, 0, 0, 2, 3, 0, 0));
      push_exp(31, "s1_idle_reject",  mk(0, 0, 0, 0, 0, 0, 2, 3, 0, 0));
      push_exp(32, "s1_first_idle",   mk(1, 0, 2, 5, 0, 0, 2, 3, 0, 0));
      drop_a = 1; tick(1); drop_a = 0;
      tick(29);
      drop_a = 1; tick(1);
      pos_ax = 3'd2; pos_ay = 3'd5; tick(1); drop_a = 0;
      tick(2);

      // s2: same-cell collision priority, occupied-cell rejection, flag toggle
      do_reset();
      set_pos(3, 3, 3, 3);
      s = cyc;
      push_exp(1,  "s2_prio_a",       mk(1, 0, 3, 3, 0, 0, 3, 3, 0, 0));
      push_exp(5,  "s2_occupied_rej", mk(1, 0, 3, 3, 0, 0, 3, 3, 0, 0));
      push_exp(21, "s2_a_explode",    mk(2, 0, 3, 3, 0, 0, 3, 3, 0, 0));
      push_exp(32, "s2_prio_b",       mk(0, 1, 3, 3, 3, 3, 3, 3, 0, 0));
      push_exp(52, "s2_b_explode",    mk(0, 2, 3, 3, 3, 3, 3, 3, 0, 0));
      drop_a = 1; drop_b = 1; tick(1); drop_a = 0; drop_b = 0;
      set_pos(7, 0, 0, 7);
      tick(3);
      pos_bx = 3'd3; pos_by = 3'd3; drop_b = 1; tick(1); drop_b = 0;
      pos_bx = 3'd0; pos_by = 3'd7;
      tick(26);
      set_pos(3, 3, 3, 3);
      drop_a = 1; drop_b = 1; tick(1); drop_a = 0; drop_b = 0;
      set_pos(7, 0, 0, 7);
      tick(22);

      // s3: chain reaction, player B at (5,3) hit only by the chained bomb
      do_reset();
      set_pos(3, 3, 6, 6);
      s = cyc;
      push_exp(1,  "s3_a_armed",      mk(1, 0, 3, 3, 0, 0, 3, 3, 0, 0));
      push_exp(6,  "s3_b_armed",      mk(1, 1, 3, 3, 4, 3, 3, 3, 0, 0));
      push_exp(21, "s3_a_explode",    mk(2, 1, 3, 3, 4, 3, 3, 3, 0, 0));
      push_exp(22, "s3_b_chain",      mk(2, 2, 3, 3, 4, 3, 3, 2, 0, 0));
      push_exp(31, "s3_a_idle",       mk(0, 2, 3, 3, 4, 3, 3, 2, 0, 0));
      push_exp(32, "s3_b_idle",       mk(0, 0, 3, 3, 4, 3, 3, 2, 0, 0));
      drop_a = 1; tick(1); drop_a = 0;
      pos_ax = 3'd0; pos_ay = 3'd7;
      tick(4);
      pos_bx = 3'd4; pos_by = 3'd3; drop_b = 1; tick(1); drop_b = 0;
      pos_bx = 3'd5; pos_by = 3'd3;
      tick(28);

      // s4: double hit, then lethal hit -> game over, forced idle, drops ignored
      do_reset();
      set_pos(2, 2, 2, 3);
      s = cyc;
      push_exp(1,  "s4_both_armed",   mk(1, 1, 2, 2, 2, 3, 3, 3, 0, 0));
      push_exp(21, "s4_double_hit",   mk(2, 2, 2, 2, 2, 3, 1, 3, 0, 0));
      push_exp(31, "s4_both_idle",    mk(0, 0, 2, 2, 2, 3, 1, 3, 0, 0));
      push_exp(32, "s4_rearm",        mk(1, 0, 2, 2, 2, 3, 1, 3, 0, 0));
      push_exp(52, "s4_game_over",    mk(2, 0, 2, 2, 2, 3, 0, 3, 1, 2));
      push_exp(53, "s4_forced_idle",  mk(0, 0, 2, 2, 2, 3, 0, 3, 1, 2));
      push_exp(54, "s4_drop_ignored", mk(0, 0, 2, 2, 2, 3, 0, 3, 1, 2));
      push_exp(60, "s4_sticky",       mk(0, 0, 2, 2, 2, 3, 0, 3, 1, 2));
      drop_a = 1; drop_b = 1; tick(1); drop_a = 0; drop_b = 0;
      pos_bx = 3'd7; pos_by = 3'd7;
      tick(30);
      drop_a = 1; tick(1); drop_a = 0;
      tick(20);
      pos_bx = 3'd5; pos_by = 3'd5; drop_b = 1; tick(2); drop_b = 0;
      tick(7);

      // s5: bomb at (0,7), edge clipping with no wrap-around in x or y
      do_reset();
      set_pos(0, 7, 1, 7);
      s = cyc;
      push_exp(1,  "s5_armed",        mk(1, 0, 0, 7, 0, 0, 3, 3, 0, 0));
      push_exp(21, "s5_hit_1_7",      mk(2, 0, 0, 7, 0, 0, 3, 2, 0, 0));
      push_exp(32, "s5_rearm",        mk(1, 0, 0, 7, 0, 0, 3, 2, 0, 0));
      push_exp(52, "s5_no_wrap",      mk(2, 0, 0, 7, 0, 0, 3, 2, 0, 0));
      push_exp(62, "s5_idle",         mk(0, 0, 0, 7, 0, 0, 3, 2, 0, 0));
      drop_a = 1; tick(1); drop_a = 0;
      pos_ax = 3'd7; pos_ay = 3'd0;
      tick(30);
      pos_ax = 3'd0; pos_ay = 3'd7; drop_a = 1; tick(1); drop_a = 0;
      set_pos(0, 0, 7, 7);
      tick(32);

      // s6: asynchronous reset mid-fuse, held past the would-be explosion
      do_reset();
      set_pos(0, 0, 7, 7);
      s = cyc;
      push_exp(1,  "s6_armed",        mk(1, 0, 0, 0, 0, 0, 3, 3, 0, 0));
      push_exp(15, "s6_mid_fuse",     mk(1, 0, 0, 0, 0, 0, 3, 3, 0, 0));
      drop_a = 1; tick(1); drop_a = 0;
      tick(15);
      rst = 1'b1;
      push_exp(0, "s6_async_reset", r0);
      tick(9);
      push_exp(0, "s6_reset_hold", r0);
      n_cmp++;
      if (bomb_state_a !== 2'd0) begin
         n_fail++;
         $display("FAIL direct_s6_slot_a: got %0d", bomb_state_a);
      end
      n_cmp++;
      if (health_a !== 2'd3 || health_b !== 2'd3) begin
         n_fail++;
         $display("FAIL direct_s6_health: got %0d %0d", health_a, health_b);
      end
      n_cmp++;
      if (game_over !== 1'b0 || winner !== 2'b00) begin
         n_fail++;
         $display("FAIL direct_s6_game: go=%0d win=%b", game_over, winner);
      end
      n_cmp++;
      if (bomb_ax !== 3'd0 || bomb_ay !== 3'd0) begin
         n_fail++;
         $display("FAIL direct_s6_coords: got (%0d,%0d)", bomb_ax, bomb_ay);
      end
      rst = 1'b0;
      tick(5);
      push_exp(0, "s6_after_release", r0);
      tick(2);

      while (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_cmp++;
         n_fail++;
         $display("FAIL %s: never compared (due cyc %0d, now %0d)", e.name, e.cyc, cyc);
      end

      if (n_fail == 0)
         $display("PASS: all checks passed");
      else
         $display("FAIL: %0d checks failed", n_fail);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
